// File: rtl/fp_mult_sched.sv
// Round-robin scheduler sharing one fp_mult between NREQ clients.
// Results return in issue order through a credit-guarded response FIFO.
module fp_mult_sched #(
   parameter int NREQ       = 4,
   parameter int LAT        = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*32-1:0]   req_a,
   input  logic [NREQ*32-1:0]   req_b,
   input  logic [NREQ*3-1:0]    req_rnd,
   output logic [31:0]          mult_a,
   output logic [31:0]          mult_b,
   output logic [2:0]           mult_rnd,
   input  logic [31:0]          mult_z,
   input  logic [7:0]           mult_status,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [31:0]          resp_z,
   output logic [7:0]           resp_status,
   output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] resp_id,
   output logic                 busy
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);

   logic [IDW-1:0] r_ptr;
   logic [LAT-1:0] r_pv;
   logic [IDW-1:0] r_pid [LAT];
   logic [31:0]    r_fz  [FIFO_DEPTH];
   logic [7:0]     r_fs  [FIFO_DEPTH];
   logic [IDW-1:0] r_fid [FIFO_DEPTH];
   logic [PW-1:0]  r_wr;
   logic [PW-1:0]  r_rd;
   logic [CW-1:0]  r_cnt;

   logic           w_found;
   logic [IDW-1:0] w_gid;
   logic [CW-1:0]  w_infl;
   logic           w_can;
   logic           w_issue;
   logic           w_push;
   logic           w_pop;

   function automatic logic [IDW-1:0] wrap_add(logic [IDW-1:0] p, int k);
      int s;
      s = int'(p) + k;
      if (s >= NREQ) s = s - NREQ;
      return IDW'(s);
   endfunction

   function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      w_found = 1'b0;
      w_gid   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && req_valid[wrap_add(r_ptr, k)]) begin
            w_found = 1'b1;
            w_gid   = wrap_add(r_ptr, k);
         end
      end
   end

   // Pops in the same cycle are deliberately not credited back.
   always_comb begin
      w_infl = '0;
      for (int i = 0; i < LAT; i++) w_infl = w_infl + CW'(r_pv[i]);
   end

   assign w_can   = rst && (({1'b0, r_cnt} + {1'b0, w_infl}) < (CW+1)'(FIFO_DEPTH));
   assign w_issue = w_found && w_can;

   always_comb begin
      req_ready = '0;
      mult_a    = '0;
      mult_b    = '0;
      mult_rnd  = '0;
      if (w_issue) begin
         req_ready[w_gid] = 1'b1;
         mult_a   = req_a[32*w_gid +: 32];
         mult_b   = req_b[32*w_gid +: 32];
         mult_rnd = req_rnd[3*w_gid +: 3];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ptr <= '0;
         r_pv  <= '0;
      end else begin
         if (w_issue) r_ptr <= wrap_add(w_gid, 1);
         r_pv[0] <= w_issue;
         for (int i = 1; i < LAT; i++) r_pv[i] <= r_pv[i-1];
      end
   end

   always_ff @(posedge clk) begin
      r_pid[0] <= w_gid;
      for (int i = 1; i < LAT; i++) r_pid[i] <= r_pid[i-1];
   end

   assign w_push     = r_pv[LAT-1];
   assign resp_valid = (r_cnt != '0);
   assign w_pop      = resp_valid && resp_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= ptr_inc(r_wr);
         if (w_pop)  r_rd <= ptr_inc(r_rd);
         if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
         else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fz[r_wr]  <= mult_z;
         r_fs[r_wr]  <= mult_status;
         r_fid[r_wr] <= r_pid[LAT-1];
      end
   end

   assign resp_z      = resp_valid ? r_fz[r_rd]  : '0;
   assign resp_status = resp_valid ? r_fs[r_rd]  : '0;
   assign resp_id     = resp_valid ? r_fid[r_rd] : '0;
   assign busy        = (|r_pv) || resp_valid;

endmodule

// File: tb/tb_fp_mult_sched.sv
// Scoreboard bench for fp_mult_sched with a behavioural 1-cycle fp_mult.
module tb_fp_mult_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic [11:0]  req_rnd;
   logic [31:0]  mult_a;
   logic [31:0]  mult_b;
   logic [2:0]   mult_rnd;
   logic [31:0]  mult_z;
   logic [7:0]   mult_status;
   logic         resp_valid;
   logic         resp_ready;
   logic [31:0]  resp_z;
   logic [7:0]   resp_status;
   logic [1:0]   resp_id;
   logic         busy;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] z;
      logic [7:0]  st;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   fp_mult_sched dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_rnd(req_rnd),
      .mult_a(mult_a), .mult_b(mult_b), .mult_rnd(mult_rnd),
      .mult_z(mult_z), .mult_status(mult_status),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_z(resp_z), .resp_status(resp_status), .resp_id(resp_id),
      .busy(busy)
   );

   // Truncating multiplier for normal operands; infinities flag status[1].
   function automatic logic [39:0] fmul(logic [31:0] a, logic [31:0] b);
      logic        s;
      logic [47:0] p;
      logic [22:0] m;
      int          e;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
         return {s, 8'hFF, 23'h0, 8'h02};
      p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         m = p[46:24];
         e = e + 1;
      end else begin
         m = p[45:23];
      end
      return {s, e[7:0], m, 8'h00};
   endfunction

   always @(posedge clk) {mult_z, mult_status} <= fmul(mult_a, mult_b);

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rnd_fp();
      logic [31:0] v;
      v[31]    = 1'($urandom_range(0, 1));
      v[30:23] = 8'($urandom_range(100, 150));
      v[22:0]  = 23'($urandom);
      return v;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         sb.delete();
      end else begin
         chk("onehot", 64'($onehot0(req_ready)), 64'd1);
         if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
               chk("sb_empty", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("resp_id", 64'(resp_id), 64'(e.id));
               chk("resp_z", 64'(resp_z), 64'(e.z));
               chk("resp_st", 64'(resp_status), 64'(e.st));
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               e.id = 2'(i);
               {e.z, e.st} = fmul(req_a[32*i +: 32], req_b[32*i +: 32]);
               sb.push_back(e);
            end
         end
      end
   end

   task automatic edge_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic rand_ops();
      for (int i = 0; i < 4; i++) begin
         req_a[32*i +: 32] = rnd_fp();
         req_b[32*i +: 32] = rnd_fp();
         req_rnd[3*i +: 3] = 3'($urandom_range(0, 4));
      end
   endtask

   initial begin
      int n;
      rst        = 1'b0;
      req_valid  = 4'hF;
      resp_ready = 1'b1;
      rand_ops();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_rvalid", 64'(resp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ma", 64'(mult_a), 64'd0);
      chk("rst_mb", 64'(mult_b), 64'd0);
      chk("rst_rz", 64'(resp_z), 64'd0);
      edge_drive();
      rst       = 1'b1;
      req_valid = 4'h0;

      req_a[31:0] = 32'h3FC00000;
      req_b[31:0] = 32'h40000000;
      req_rnd[2:0] = 3'd0;
      req_valid   = 4'b0001;
      @(negedge clk);
      chk("one_ready", 64'(req_ready), 64'h1);
      chk("one_ma", 64'(mult_a), 64'h3FC00000);
      edge_drive();
      req_valid = 4'h0;
      @(negedge clk);
      chk("one_early", 64'(resp_valid), 64'd0);
      @(negedge clk);
      chk("one_rvalid", 64'(resp_valid), 64'd1);
      chk("one_z", 64'(resp_z), 64'h40400000);
      chk("one_st", 64'(resp_status), 64'h00);
      chk("one_id", 64'(resp_id), 64'd0);
      wait_idle();

      edge_drive();
      rand_ops();
      req_valid = 4'hF;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("fair_grant", 64'(req_ready), 64'(4'b0001 << ((1 + i) % 4)));
         edge_drive();
         rand_ops();
      end
      req_valid = 4'h0;
      wait_idle();

      edge_drive();
      resp_ready = 1'b0;
      req_valid  = 4'hF;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (|(req_valid & req_ready)) n++;
      end
      chk("bp_issues", 64'(n), 64'd4);
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      edge_drive();
      resp_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_pop", 64'(resp_valid), 64'd1);
         if (|req_ready) n++;
      end
      chk("bp_resume", 64'(n != 0), 64'd1);
      edge_drive();
      req_valid = 4'h0;
      wait_idle();

      edge_drive();
      req_a[95:64] = 32'h7F800000;
      req_b[95:64] = 32'h40000000;
      req_valid    = 4'b0100;
      edge_drive();
      req_valid = 4'h0;
      n = 0;
      @(negedge clk);
      while (!resp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("exc_valid", 64'(resp_valid), 64'd1);
      chk("exc_z", 64'(resp_z), 64'h7F800000);
      chk("exc_inf", 64'(resp_status[1]), 64'd1);
      chk("exc_id", 64'(resp_id), 64'd2);
      wait_idle();

      edge_drive();
      resp_ready = 1'b0;
      req_valid  = 4'b0011;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      req_valid = 4'h0;
      edge_drive();
      rst = 1'b1;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (resp_valid) n++;
      end
      chk("mid_rvalid", 64'(n), 64'd0);
      chk("mid_busy", 64'(busy), 64'd0);
      edge_drive();
      resp_ready = 1'b1;
      rand_ops();
      req_valid = 4'hF;
      @(negedge clk);
      chk("mid_grant", 64'(req_ready), 64'h1);
      repeat (3) edge_drive();
      req_valid = 4'h0;
      wait_idle();
      @(negedge clk);
      chk("sb_drain", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
